// File: rtl/imem_line_fetcher.sv
// Instruction-memory line fetcher: turns one fetch-stage line request into a
// single fixed-length read burst and returns the assembled line as a one-cycle response.
module imem_line_fetcher #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   req_valid,
    output logic [BUFFER_SIZE-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0]  resp_addr,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [ADDR_WIDTH-1:0]  mem_araddr,
    output logic [7:0]             mem_arlen,
    output logic                   mem_arvalid,
    input  logic                   mem_arready,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_rvalid,
    input  logic                   mem_rlast,
    input  logic [1:0]             mem_rresp,
    output logic                   mem_rready
);

    localparam int BEATS       = BUFFER_SIZE / DATA_WIDTH;
    localparam int LINE_BYTES  = BUFFER_SIZE / 8;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int CNT_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);
    localparam logic [7:0]           ARLEN     = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_armed;
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [BUFFER_SIZE-1:0] r_resp_data;
    logic [ADDR_WIDTH-1:0]  r_resp_addr;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic                   r_arvalid;
    logic                   r_rready;

    logic [ADDR_WIDTH-1:0]  w_line_base;
    logic                   w_last_beat;
    logic                   w_beat_err;

    assign w_line_base = {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign w_last_beat = (r_cnt == LAST_BEAT);
    // A misplaced or missing rlast is a framing error, but the line length is fixed by the counter.
    assign w_beat_err  = (mem_rresp != 2'b00)
                       | (mem_rlast & ~w_last_beat)
                       | (~mem_rlast & w_last_beat);

    assign resp_data   = r_resp_data;
    assign resp_addr   = r_resp_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign mem_araddr  = r_base;
    assign mem_arlen   = ARLEN;
    assign mem_arvalid = r_arvalid;
    assign mem_rready  = r_rready;

    // Fetch FSM with its registered handshake strobes, line buffer and response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_WIDTH{1'b0}};
            r_armed      <= 1'b1;
            r_err        <= 1'b0;
            r_base       <= {ADDR_WIDTH{1'b0}};
            r_resp_data  <= {BUFFER_SIZE{1'b0}};
            r_resp_addr  <= {ADDR_WIDTH{1'b0}};
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
        end else begin
            // A request level still held after its response must drop once before re-arming.
            if (!req_valid) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_armed) begin
                        r_base    <= w_line_base;
                        r_cnt     <= {CNT_WIDTH{1'b0}};
                        r_err     <= 1'b0;
                        r_armed   <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mem_rvalid) begin
                        r_resp_data[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        r_err <= r_err | w_beat_err;
                        if (w_last_beat) begin
                            r_rready     <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_resp_addr  <= r_base;
                            r_resp_err   <= r_err | w_beat_err;
                            r_state      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_arvalid    <= 1'b0;
                    r_rready     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_fetcher.sv
// Directed bench for imem_line_fetcher: a table of line fetches against a
// scripted memory responder, plus re-arm and mid-burst reset sequences.
module tb_imem_line_fetcher;

    localparam int BEATS = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  req_addr;
    logic         req_valid;
    logic [511:0] resp_data;
    logic [63:0]  resp_addr;
    logic         resp_valid;
    logic         resp_err;
    logic [63:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic         mem_arvalid;
    logic         mem_arready;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;
    logic         mem_rlast;
    logic [1:0]   mem_rresp;
    logic         mem_rready;

    int n_total  = 0;
    int n_passed = 0;

    typedef struct {
        logic [63:0] addr;
        int          ar_delay;
        bit          bubbles;
        int          err_beat;
        int          rlast_beat;
        logic [63:0] seed;
        logic [63:0] exp_base;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    imem_line_fetcher dut (
        .clk         (clk),
        .reset       (reset),
        .req_addr    (req_addr),
        .req_valid   (req_valid),
        .resp_data   (resp_data),
        .resp_addr   (resp_addr),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rlast   (mem_rlast),
        .mem_rresp   (mem_rresp),
        .mem_rready  (mem_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_mem();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
        mem_rresp   = 2'd0;
        mem_rdata   = 64'd0;
    endtask

    // One line fetch; cycle 0 is the cycle in which req_valid is first presented.
    task automatic run_line(input vec_t v, input int hold, input string tag);
        int           cyc = 0;
        int           resp_cyc = -1;
        int           pulses = 0;
        int           bursts = 0;
        int           beats = 0;
        int           stall = 0;
        bit           prev_arv = 1'b0;
        bit           ar_ok = 1'b1;
        bit           toggle = 1'b1;
        bit           done = 1'b0;
        logic [63:0]  cap_addr = 64'd0;
        logic         cap_err = 1'b0;
        logic [511:0] cap_data = 512'd0;
        logic [511:0] exp_line;
        for (int k = 0; k < BEATS; k++) begin
            exp_line[k*64 +: 64] = v.seed + 64'(k);
        end
        req_addr  = v.addr;
        req_valid = 1'b1;
        idle_mem();
        while (!done && cyc < 200) begin
            step();
            cyc++;
            if (mem_arvalid && !prev_arv) bursts++;
            if (mem_arvalid && mem_araddr !== v.exp_base) ar_ok = 1'b0;
            prev_arv = mem_arvalid;
            if (resp_valid) begin
                pulses++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    cap_addr = resp_addr;
                    cap_err  = resp_err;
                    cap_data = resp_data;
                end
            end
            idle_mem();
            if (mem_arvalid) begin
                if (stall >= v.ar_delay) mem_arready = 1'b1;
                else stall++;
            end
            if (mem_rready && beats < BEATS) begin
                if (!v.bubbles || toggle) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.seed + 64'(beats);
                    mem_rlast  = (beats == v.rlast_beat);
                    mem_rresp  = (beats == v.err_beat) ? 2'd2 : 2'd0;
                    beats++;
                end
                toggle = !toggle;
            end
            if (resp_cyc >= 0 && cyc - resp_cyc > hold) req_valid = 1'b0;
            if (resp_cyc >= 0 && cyc - resp_cyc > hold + 1) done = 1'b1;
        end
        req_valid = 1'b0;
        idle_mem();
        chk({tag, "_finished"}, 512'(done), 512'(1));
        chk({tag, "_latency"}, 512'(resp_cyc), 512'(v.exp_lat));
        chk({tag, "_bursts"}, 512'(bursts), 512'(1));
        chk({tag, "_araddr"}, 512'(ar_ok), 512'(1));
        chk({tag, "_arlen"}, 512'(mem_arlen), 512'(7));
        chk({tag, "_beats"}, 512'(beats), 512'(BEATS));
        chk({tag, "_pulses"}, 512'(pulses), 512'(1));
        chk({tag, "_resp_addr"}, 512'(cap_addr), 512'(v.exp_base));
        chk({tag, "_resp_err"}, 512'(cap_err), 512'(v.exp_err));
        chk({tag, "_resp_data"}, cap_data, exp_line);
        chk({tag, "_data_held"}, resp_data, exp_line);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 512'(resp_valid), 512'(0));
        chk({tag, "_resp_err"}, 512'(resp_err), 512'(0));
        chk({tag, "_resp_data"}, resp_data, 512'(0));
        chk({tag, "_resp_addr"}, 512'(resp_addr), 512'(0));
        chk({tag, "_arvalid"}, 512'(mem_arvalid), 512'(0));
        chk({tag, "_rready"}, 512'(mem_rready), 512'(0));
        chk({tag, "_araddr"}, 512'(mem_araddr), 512'(0));
    endtask

    initial begin
        vec_t v;
        bit   reached;
        int   beats;

        vecs[0] = '{64'h1234, 0, 1'b0, 99, 7, 64'h0, 64'h1200, 1'b0, 10};
        vecs[1] = '{64'h1234, 3, 1'b1, 99, 7, 64'h0, 64'h1200, 1'b0, 20};
        vecs[2] = '{64'h3FFF, 0, 1'b0, 3, 7, 64'h100, 64'h3FC0, 1'b1, 10};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF9, 0, 1'b0, 99, 5, 64'hA5A5_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 10};
        vecs[4] = '{64'h8000_0000_0000_007F, 1, 1'b0, 99, 99, 64'h55,
                    64'h8000_0000_0000_0040, 1'b1, 11};
        vecs[5] = '{64'h40, 0, 1'b1, 99, 7, 64'hDEAD_BEEF_0000_0000, 64'h40, 1'b0, 17};

        reset     = 1'b1;
        req_addr  = 64'd0;
        req_valid = 1'b0;
        idle_mem();
        repeat (3) step();
        chk_all_zero("reset");
        chk("reset_arlen", 512'(mem_arlen), 512'(7));
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_line(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Level-held request must not start a second burst; re-arm after one low cycle.
        v = vecs[0];
        run_line(v, 2, "hold");
        v = '{64'h2040, 0, 1'b0, 99, 7, 64'h2040_0000, 64'h2040, 1'b0, 10};
        run_line(v, 0, "rearm");

        // Reset lands together with beat 4 of a burst.
        req_addr  = 64'h1234;
        req_valid = 1'b1;
        reached   = 1'b0;
        beats     = 0;
        for (int c = 0; c < 40 && !reached; c++) begin
            step();
            idle_mem();
            mem_arready = mem_arvalid;
            if (mem_rready) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'(beats) + 64'h77;
                if (beats == 4) begin
                    reset   = 1'b1;
                    reached = 1'b1;
                end
                beats++;
            end
        end
        chk("midrst_reached", 512'(reached), 512'(1));
        step();
        chk_all_zero("midrst");
        reset     = 1'b0;
        req_valid = 1'b0;
        idle_mem();
        v = '{64'h40, 0, 1'b0, 99, 7, 64'h9, 64'h40, 1'b0, 10};
        run_line(v, 0, "postrst");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
